// File: rtl/return_stack_pkg.sv
// Shared constants for the return-address stack and the PC unit around it.
// Holds the default stack depth, the address width and the PC-source
// encoding the control unit uses to pair sig_pop with top-of-stack selection.
package return_stack_pkg;

    localparam int RSTACK_DEPTH = 8;
    localparam int ADDR_WIDTH   = 32;

    typedef enum logic [1:0] {
        PC_SRC_INC    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_TOS    = 2'd3
    } pc_src_e;

endpackage

// File: rtl/return_stack_mem.sv
// DEPTH x WIDTH register array with one write port and one asynchronous
// read port; every entry clears to 0 on reset.
module return_stack_mem
    import return_stack_pkg::*;
#(
    parameter int DEPTH = RSTACK_DEPTH,
    parameter int WIDTH = ADDR_WIDTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: at most one entry is overwritten per cycle.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack feeding the PC unit's top-of-stack bus.
// CALL pushes PC + 1; RET pops, with topstack readable on the same edge.
// Optional macro RSTACK_WRAP_EN: a push while full overwrites the oldest
// entry (circular behaviour) instead of being rejected.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int DEPTH = RSTACK_DEPTH,
    parameter int WIDTH = ADDR_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       sig_push,
    input  logic                       sig_pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           topstack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [IDX_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] next_idx;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             is_empty;
    logic             is_full;

    // Explicit modulo-DEPTH neighbours of the write index (DEPTH need not be 2^n).
    always_comb begin
        top_idx  = (widx_q == '0) ? LAST_IDX : widx_q - IDX_W'(1);
        next_idx = (widx_q == LAST_IDX) ? '0 : widx_q + IDX_W'(1);
        is_empty = (count_q == '0);
        is_full  = (count_q == DEPTH_CNT);
    end

    // Next-state for index, count and sticky flags plus the storage write port.
    always_comb begin
        widx_d      = widx_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = widx_q;
        if (sig_push && sig_pop && !is_empty) begin
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end else if (sig_push) begin
            if (!is_full) begin
                mem_we  = 1'b1;
                widx_d  = next_idx;
                count_d = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
`ifdef RSTACK_WRAP_EN
                mem_we     = 1'b1;
                widx_d     = next_idx;
`endif
            end
        end else if (sig_pop) begin
            if (!is_empty) begin
                widx_d  = top_idx;
                count_d = count_q - CNT_W'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer, count and flag registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            widx_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            widx_q      <= widx_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    return_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (push_data),
        .raddr   (top_idx),
        .rdata   (mem_rdata)
    );

    assign topstack  = is_empty ? '0 : mem_rdata;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack using a queue-based reference stack
// and a scoreboard of expected observations.
module tb_return_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset_n;
    logic             sig_push;
    logic             sig_pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] topstack;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        scoreboard[$];
    logic [31:0] ref_stack[$];
    logic        ref_ovf;
    logic        ref_udf;
    int          checks;
    int          errors;

    return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sig_push  (sig_push),
        .sig_pop   (sig_pop),
        .push_data (push_data),
        .topstack  (topstack),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] sampleDut(input string tag);
        case (tag)
            "top":   return topstack;
            "count": return 32'(count);
            "empty": return {31'd0, empty};
            "full":  return {31'd0, full};
            "ovf":   return {31'd0, overflow};
            "udf":   return {31'd0, underflow};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] refTop();
        return (ref_stack.size() == 0) ? 32'd0 : ref_stack[ref_stack.size() - 1];
    endfunction

    // Queue the full set of observable outputs predicted by the reference.
    task automatic expectAll();
        scoreboard.push_back('{"top",   refTop()});
        scoreboard.push_back('{"count", 32'(ref_stack.size())});
        scoreboard.push_back('{"empty", {31'd0, ref_stack.size() == 0}});
        scoreboard.push_back('{"full",  {31'd0, ref_stack.size() == DEPTH}});
        scoreboard.push_back('{"ovf",   {31'd0, ref_ovf}});
        scoreboard.push_back('{"udf",   {31'd0, ref_udf}});
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, sampleDut(e.tag), e.value);
        end
    endtask

    // One clock of stimulus: check the pre-edge top, drive, update reference, compare.
    task automatic applyStimulus(input logic push, input logic pop, input logic [31:0] data);
        @(negedge clock);
        checkOutput("top_pre_edge", topstack, refTop());
        sig_push  = push;
        sig_pop   = pop;
        push_data = data;
        @(posedge clock);
        #1;
        sig_push = 1'b0;
        sig_pop  = 1'b0;
        if (push && pop && ref_stack.size() > 0) begin
            ref_stack[ref_stack.size() - 1] = data;
        end else if (push) begin
            if (ref_stack.size() < DEPTH) begin
                ref_stack.push_back(data);
            end else begin
                ref_ovf = 1'b1;
`ifdef RSTACK_WRAP_EN
                void'(ref_stack.pop_front());
                ref_stack.push_back(data);
`endif
            end
        end else if (pop) begin
            if (ref_stack.size() > 0) void'(ref_stack.pop_back());
            else ref_udf = 1'b1;
        end
        expectAll();
        drainScoreboard();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ref_ovf   = 1'b0;
        ref_udf   = 1'b0;
        sig_push  = 1'b0;
        sig_pop   = 1'b0;
        push_data = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] push three, pop three");
        applyStimulus(1'b1, 1'b0, 32'h10);
        applyStimulus(1'b1, 1'b0, 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h30);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0);

        $display("[TB] fill and push past full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i));
        applyStimulus(1'b1, 1'b0, 32'h108);
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 32'h0);

        $display("[TB] underflow then push");
        applyStimulus(1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h55);
        applyStimulus(1'b0, 1'b1, 32'h0);

        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, 1'b1, 32'h77);
        applyStimulus(1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'hA);
        applyStimulus(1'b1, 1'b0, 32'hB);
        applyStimulus(1'b1, 1'b1, 32'hC);
        applyStimulus(1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 1'b0, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h2);
        applyStimulus(1'b1, 1'b0, 32'h3);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        ref_stack.delete();
        ref_ovf = 1'b0;
        ref_udf = 1'b0;
        expectAll();
        drainScoreboard();
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h99);
        applyStimulus(1'b0, 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
Hardware return-address stack that feeds the PC unit's top-of-stack bus.
- CALL pushes the return address (PC + 1).
- RET pops, and the PC unit loads the top-of-stack value on the same clock edge.
- Sits beside the PC register. The push and pop strobes come from the control unit.

Parameters:
- DEPTH, 8, number of return-address entries; must be at least 2, no power-of-2 requirement.
- WIDTH, 32, address width; matches the PC width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sig_push  input  1  CALL strobe; push push_data this cycle.
- sig_pop  input  1  RET strobe; pop the top entry this cycle.
- push_data  input  WIDTH  return address to push (PC + 1).
- topstack  output  WIDTH  current top entry; combinational from state; 0 when empty.
- count  output  clog2(DEPTH+1)  number of valid entries.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- overflow  output  1  sticky; set by a push that finds the stack full.
- underflow  output  1  sticky; set by a pop that finds the stack empty.

Behaviour:
- Reset (async, reset_n low):
  - Write index, count, overflow and underflow all go to 0. The write index is the slot the next push writes.
  - Storage array cleared to 0; topstack = 0, empty = 1, full = 0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Read path:
  - topstack = mem[(widx - 1) mod DEPTH] when count > 0, else 0.
  - Zero latency, so the PC unit captures the popped address on the same edge that executes the pop.
- Push only (sig_push = 1, sig_pop = 0):
  - Not full: mem[widx] <= push_data; widx <= (widx + 1) mod DEPTH; count + 1.
  - Full: handled as below, with or without RSTACK_WRAP_EN.
- Pop only (sig_pop = 1, sig_push = 0):
  - Not empty: widx <= (widx - 1) mod DEPTH; count - 1. The entry contents are left as is.
  - Empty: no state change except underflow <= 1. topstack stays 0.
- Push and pop together:
  - Not empty (including full): the top entry is replaced, i.e. mem[(widx - 1) mod DEPTH] <= push_data. widx and count are unchanged and no flag is set.
  - Empty: treated as push only. underflow is not set.
- Neither strobe: hold all state.
- Index arithmetic: wrap explicitly, so DEPTH - 1 + 1 becomes 0 and 0 - 1 becomes DEPTH - 1. No reliance on natural binary wrap.
- Sticky flags: overflow and underflow clear only on reset.
- No state machine: all state is the index, the count, the storage array and the flags.

Optional Feature:
Macro RSTACK_WRAP_EN.
- Defined: a push while full is accepted.
  - mem[widx] <= push_data; widx advances mod DEPTH; count stays DEPTH.
  - The oldest entry is silently lost; overflow <= 1.
  - Gives circular-buffer behaviour for deep recursion.
- Not defined: a push while full is rejected.
  - No write; widx and count are unchanged; overflow <= 1; topstack keeps its value.

Decomposition:
- Shared constants file (constants.v) gets:
  - RSTACK_DEPTH default;
  - ADDR_WIDTH (32);
  - the existing PC-source encoding for top-of-stack, which the control unit uses to pair sig_pop with the PC selection.
- Optional sub-module rstack_mem: DEPTH x WIDTH register array with one write port and one asynchronous read port, reset to 0.
- Pointer and count logic stays in return_stack.

Test Plan:
- Reset, then no strobes → count = 0, empty = 1, full = 0, topstack = 0, overflow = 0, underflow = 0.
- Push 0x10, 0x20, 0x30, then pop 3 times → topstack reads 0x30, 0x20, 0x10 before each respective pop edge. After the last pop, empty = 1 and topstack = 0.
- Push 0x100 to 0x107 (DEPTH = 8), then push 0x108:
  - Without RSTACK_WRAP_EN → full = 1, topstack = 0x107, overflow = 1, count = 8.
  - With RSTACK_WRAP_EN → topstack = 0x108, count = 8, overflow = 1; 8 pops return 0x108 down to 0x101.
- Pop on empty → underflow = 1, count = 0. A following push of 0x55 → topstack = 0x55, and underflow stays 1.
- Push 0xA, push 0xB, then push and pop together with 0xC → count = 2, topstack = 0xC; next pop → topstack = 0xA.
- Push 3 entries, assert reset_n low between clock edges → count, empty and topstack update immediately to 0, 1 and 0 with no clock edge.
